// File: rtl/ps2_keyboard_pkg.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_pkg
// Shared constants and types for the PS/2 keyboard receive path:
//   - scan-code prefixes (break F0, extended E0)
//   - frame geometry (11-bit frame: start, 8 data, parity, stop)
//   - frame receiver FSM state encoding
//   - odd-parity check helper
// ---------------------------------------------------------------------------
package ps2_keyboard_pkg;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   localparam int FRAME_LEN = 11;
   // Start, parity and stop surround the payload.
   localparam int DATA_BITS = FRAME_LEN - 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_e;

   // PS/2 uses odd parity: data bits plus parity bit hold an odd number of 1s.
   function automatic logic parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Deserialises 11-bit PS/2 device-to-host frames.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ps2_clk   raw PS/2 clock (asynchronous)
//   ps2_data  raw PS/2 data (asynchronous)
//   rx_data   last good frame byte
//   rx_valid  one-cycle pulse per good frame
//   frame_err one-cycle pulse on parity/stop error or mid-frame timeout
// ---------------------------------------------------------------------------
module ps2_frame_rx
   import ps2_keyboard_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_prev_q;
   logic                   clk_s;
   logic                   data_s;
   logic                   fall;

   rx_state_e              state_q;
   logic [2:0]             bit_cnt_q;
   logic [7:0]             shift_q;
   logic                   par_q;
   logic [CNT_W-1:0]       tmo_q;

   // Synchronisers preset to the idle-high bus level so that releasing
   // reset never produces a phantom falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
         clk_prev_q  <= clk_s;
      end
   end

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];
   assign fall   = clk_prev_q & ~clk_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;

         if (state_q == ST_IDLE || fall) begin
            tmo_q <= '0;
         end else begin
            tmo_q <= tmo_q + CNT_W'(1);
         end

         // A device edge takes priority over a simultaneous terminal count.
         if (fall) begin
            unique case (state_q)
               ST_IDLE: begin
                  // A high start bit is a spurious edge and is dropped silently.
                  if (!data_s) begin
                     state_q   <= ST_SHIFT;
                     bit_cnt_q <= '0;
                  end
               end
               ST_SHIFT: begin
                  shift_q   <= {data_s, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_q <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  par_q   <= data_s;
                  state_q <= ST_STOP;
               end
               ST_STOP: begin
                  if (data_s && parity_ok(shift_q, par_q)) begin
                     rx_data  <= shift_q;
                     rx_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end else if (state_q != ST_IDLE && tmo_q == CNT_LAST) begin
            state_q   <= ST_IDLE;
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_keyboard.sv
// ---------------------------------------------------------------------------
// ps2_keyboard
// PS/2 keyboard receiver with make/break and extended-prefix decoding into a
// held-key view consumed by the key-mapping parser.
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   ps2_clk, ps2_data  raw PS/2 lines from the keyboard (inputs only)
//   ps2_byte           scan code of the last pressed key, prefixes stripped
//   ps2_state          1 while ps2_byte is held
//   ps2_ext            1 if ps2_byte was E0-prefixed
//   rx_data            last good raw frame byte (includes F0/E0)
//   rx_valid           one-cycle pulse per good frame
//   frame_err          one-cycle pulse on a bad or timed-out frame
// ---------------------------------------------------------------------------
module ps2_keyboard
   import ps2_keyboard_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] ps2_byte,
   output logic       ps2_state,
   output logic       ps2_ext,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err
);

   logic [7:0] byte_q,     byte_d;
   logic       state_q,    state_d;
   logic       ext_q,      ext_d;
   logic       brk_pend_q, brk_pend_d;
   logic       ext_pend_q, ext_pend_d;

   ps2_frame_rx #(
      .SYNC_STAGES   (SYNC_STAGES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err)
   );

   // Error frames never reach here: only rx_valid advances the decoder.
   always_comb begin
      byte_d     = byte_q;
      state_d    = state_q;
      ext_d      = ext_q;
      brk_pend_d = brk_pend_q;
      ext_pend_d = ext_pend_q;
      if (rx_valid) begin
         if (rx_data == PS2_BREAK) begin
            brk_pend_d = 1'b1;
         end else if (rx_data == PS2_EXT) begin
            ext_pend_d = 1'b1;
         end else if (brk_pend_q) begin
            // Releasing a key other than the held one leaves the view alone.
            if (rx_data == byte_q && ext_pend_q == ext_q) begin
               state_d = 1'b0;
            end
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
         end else begin
            // Typematic repeats rewrite identical values, so no glitch.
            byte_d     = rx_data;
            ext_d      = ext_pend_q;
            state_d    = 1'b1;
            ext_pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_q     <= '0;
         state_q    <= 1'b0;
         ext_q      <= 1'b0;
         brk_pend_q <= 1'b0;
         ext_pend_q <= 1'b0;
      end else begin
         byte_q     <= byte_d;
         state_q    <= state_d;
         ext_q      <= ext_d;
         brk_pend_q <= brk_pend_d;
         ext_pend_q <= ext_pend_d;
      end
   end

   assign ps2_byte  = byte_q;
   assign ps2_state = state_q;
   assign ps2_ext   = ext_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
module tb_ps2_keyboard;

   localparam int TO = 2000;   // shortened timeout for simulation
   localparam int H  = 20;     // PS/2 clock half period in system clocks

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] ps2_byte;
   logic       ps2_state;
   logic       ps2_ext;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;

   int checks = 0;
   int fails  = 0;

   // Monitor state
   int         vld_cnt = 0;
   int         err_cnt = 0;
   int         glitch  = 0;
   logic       watch   = 1'b0;
   logic       vld_prev = 1'b0;
   logic [7:0] last_rx = 8'h00;
   logic [7:0] after_byte = 8'h00;
   logic       after_state = 1'b0;
   logic       after_ext = 1'b0;

   ps2_keyboard #(
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .ps2_byte (ps2_byte),
      .ps2_state(ps2_state),
      .ps2_ext  (ps2_ext),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Sample away from the active edge; capture decoder outputs exactly one
   // cycle after each rx_valid to pin the N+2 latency.
   always @(negedge clk) begin
      if (vld_prev) begin
         after_byte  = ps2_byte;
         after_state = ps2_state;
         after_ext   = ps2_ext;
      end
      if (rx_valid === 1'b1) begin
         vld_cnt = vld_cnt + 1;
         last_rx = rx_data;
      end
      if (frame_err === 1'b1) err_cnt = err_cnt + 1;
      if (watch && ps2_state !== 1'b1) glitch = glitch + 1;
      vld_prev = (rx_valid === 1'b1);
   end

   task automatic ps2_bit(input logic b);
      @(negedge clk); ps2_data = b;
      repeat (H) @(negedge clk); ps2_clk = 1'b0;
      repeat (H) @(negedge clk); ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip_par,
                             input logic stop_bit, input int nbits);
      logic [10:0] fr;
      fr = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
      ps2_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 11);
      repeat (4 * H) @(negedge clk);
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (ps2_byte !== 8'h00) begin fails++; $display("FAIL reset_byte: got %h expected 00", ps2_byte); end
      checks++; if (ps2_state !== 1'b0) begin fails++; $display("FAIL reset_state: got %b expected 0", ps2_state); end
      checks++; if (ps2_ext !== 1'b0) begin fails++; $display("FAIL reset_ext: got %b expected 0", ps2_ext); end
      checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      rst_n = 1'b1;
      repeat (1000) @(negedge clk);
      checks++; if (vld_cnt !== 0) begin fails++; $display("FAIL idle_valid: got %0d pulses expected 0", vld_cnt); end
      checks++; if (err_cnt !== 0) begin fails++; $display("FAIL idle_err: got %0d pulses expected 0", err_cnt); end
   endtask

   task automatic test_single;
      int v0, e0;
      v0 = vld_cnt; e0 = err_cnt;
      send(8'h1D);
      checks++; if (vld_cnt - v0 !== 1) begin fails++; $display("FAIL single_valid: got %0d cycles expected 1", vld_cnt - v0); end
      checks++; if (last_rx !== 8'h1D) begin fails++; $display("FAIL single_rx: got %h expected 1d", last_rx); end
      checks++; if (after_byte !== 8'h1D) begin fails++; $display("FAIL single_byte: got %h expected 1d", after_byte); end
      checks++; if (after_state !== 1'b1) begin fails++; $display("FAIL single_state: got %b expected 1", after_state); end
      checks++; if (after_ext !== 1'b0) begin fails++; $display("FAIL single_ext: got %b expected 0", after_ext); end
      checks++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL single_err: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_ext;
      send(8'hE0); send(8'h75);
      checks++; if (ps2_byte !== 8'h75) begin fails++; $display("FAIL ext_press_byte: got %h expected 75", ps2_byte); end
      checks++; if (ps2_ext !== 1'b1) begin fails++; $display("FAIL ext_press_ext: got %b expected 1", ps2_ext); end
      checks++; if (ps2_state !== 1'b1) begin fails++; $display("FAIL ext_press_state: got %b expected 1", ps2_state); end
      send(8'hE0); send(8'hF0);
      checks++; if (ps2_state !== 1'b1) begin fails++; $display("FAIL ext_prefix_hold: got %b expected 1", ps2_state); end
      send(8'h75);
      checks++; if (ps2_state !== 1'b0) begin fails++; $display("FAIL ext_release_state: got %b expected 0", ps2_state); end
      checks++; if (ps2_byte !== 8'h75) begin fails++; $display("FAIL ext_release_byte: got %h expected 75", ps2_byte); end
   endtask

   task automatic test_two_keys;
      send(8'h23); send(8'h29);
      send(8'hF0); send(8'h23);
      checks++; if (ps2_byte !== 8'h29) begin fails++; $display("FAIL two_keys_byte: got %h expected 29", ps2_byte); end
      checks++; if (ps2_state !== 1'b1) begin fails++; $display("FAIL two_keys_state: got %b expected 1", ps2_state); end
      checks++; if (ps2_ext !== 1'b0) begin fails++; $display("FAIL two_keys_ext: got %b expected 0", ps2_ext); end
      send(8'hF0); send(8'h29);
      checks++; if (ps2_state !== 1'b0) begin fails++; $display("FAIL two_keys_release: got %b expected 0", ps2_state); end
   endtask

   task automatic test_bad_frames;
      int v0, e0;
      send(8'h1C);
      v0 = vld_cnt; e0 = err_cnt;
      send_frame(8'h5A, 1'b1, 1'b1, 11);
      repeat (4 * H) @(negedge clk);
      checks++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL parity_err: got %0d cycles expected 1", err_cnt - e0); end
      checks++; if (vld_cnt - v0 !== 0) begin fails++; $display("FAIL parity_valid: got %0d expected 0", vld_cnt - v0); end
      checks++; if (ps2_byte !== 8'h1C) begin fails++; $display("FAIL parity_byte: got %h expected 1c", ps2_byte); end
      checks++; if (ps2_state !== 1'b1) begin fails++; $display("FAIL parity_state: got %b expected 1", ps2_state); end
      e0 = err_cnt;
      send_frame(8'h5A, 1'b0, 1'b0, 11);
      repeat (4 * H) @(negedge clk);
      checks++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL stop_err: got %0d cycles expected 1", err_cnt - e0); end
      checks++; if (vld_cnt - v0 !== 0) begin fails++; $display("FAIL stop_valid: got %0d expected 0", vld_cnt - v0); end
   endtask

   task automatic test_timeout;
      int v0, e0, waited;
      v0 = vld_cnt; e0 = err_cnt; waited = 0;
      send_frame(8'hA6, 1'b0, 1'b1, 5);   // start + 4 data bits, then clock stops
      while (err_cnt == e0 && waited < TO + 200) begin
         @(negedge clk); waited++;
      end
      repeat (10) @(negedge clk);
      checks++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL timeout_err: got %0d cycles expected 1", err_cnt - e0); end
      checks++; if (waited < TO - H - 5 || waited > TO - H + 10) begin fails++; $display("FAIL timeout_delay: got %0d expected about %0d", waited, TO - H); end
      checks++; if (vld_cnt - v0 !== 0) begin fails++; $display("FAIL timeout_valid: got %0d expected 0", vld_cnt - v0); end
      send(8'h54);
      checks++; if (last_rx !== 8'h54) begin fails++; $display("FAIL timeout_recover_rx: got %h expected 54", last_rx); end
      checks++; if (ps2_byte !== 8'h54) begin fails++; $display("FAIL timeout_recover_byte: got %h expected 54", ps2_byte); end
      checks++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL timeout_recover_err: got %0d expected 1", err_cnt - e0); end
   endtask

   task automatic test_back_to_back;
      int v0;
      send(8'h4B);
      v0 = vld_cnt;
      watch = 1'b1;
      send(8'h4B); send(8'h4B); send(8'h4B);
      watch = 1'b0;
      checks++; if (glitch !== 0) begin fails++; $display("FAIL repeat_glitch: got %0d low cycles expected 0", glitch); end
      checks++; if (vld_cnt - v0 !== 3) begin fails++; $display("FAIL repeat_valid: got %0d expected 3", vld_cnt - v0); end
      checks++; if (ps2_byte !== 8'h4B) begin fails++; $display("FAIL repeat_byte: got %h expected 4b", ps2_byte); end
   endtask

   task automatic test_reset_mid;
      int v0, e0;
      send_frame(8'h33, 1'b0, 1'b1, 6);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (ps2_byte !== 8'h00) begin fails++; $display("FAIL midrst_byte: got %h expected 00", ps2_byte); end
      checks++; if (ps2_state !== 1'b0) begin fails++; $display("FAIL midrst_state: got %b expected 0", ps2_state); end
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      v0 = vld_cnt; e0 = err_cnt;
      send(8'h21);
      checks++; if (vld_cnt - v0 !== 1) begin fails++; $display("FAIL midrst_valid: got %0d expected 1", vld_cnt - v0); end
      checks++; if (last_rx !== 8'h21) begin fails++; $display("FAIL midrst_rx: got %h expected 21", last_rx); end
      checks++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL midrst_err: got %0d expected 0", err_cnt - e0); end
      checks++; if (ps2_byte !== 8'h21 || ps2_state !== 1'b1) begin fails++; $display("FAIL midrst_key: got %h/%b expected 21/1", ps2_byte, ps2_state); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_ext;
      test_two_keys;
      test_bad_frames;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
